// File: rtl/xheep_exit_status_reporter.sv
// Sticky capture of the first x_heep program exit, pass/fail LED and 4-phase PS handshake.
// Optional watchdog record enabled by defining XHEEP_EXIT_WATCHDOG_TIMEOUT_EN.
module xheep_exit_status_reporter #(
  parameter int unsigned BLINK_DIV_LOG2  = 24,
  parameter int unsigned ACK_SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  input  logic        ps_ack_i,
  output logic        ps_req_o,
  output logic [31:0] ps_code_o,
  output logic        ps_pass_o,
  output logic        led_status_o,
  output logic [1:0]  state_o,
  output logic [7:0]  repeat_cnt_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    ACK_LOW = 2'b10,
    DONE    = 2'b11
  } state_e;

  state_e                    state_q, state_d;
  logic                      valid_q;
  logic [ACK_SYNC_STAGES-1:0] ack_sync_q;
  logic [31:0]               code_q, code_d;
  logic                      pass_q, pass_d;
  logic                      req_q, req_d;
  logic                      led_q, led_d;
  logic                      tmo_q, tmo_d;
  logic [7:0]                rpt_q, rpt_d;
  logic [BLINK_DIV_LOG2-1:0] blink_q, blink_d;
  logic                      rise, ack_s, wd_fire;

  assign rise  = exit_valid_i & ~valid_q;
  assign ack_s = ack_sync_q[ACK_SYNC_STAGES-1];

`ifdef XHEEP_EXIT_WATCHDOG_TIMEOUT_EN
  logic [31:0] wd_cnt_q;

  // Counts only while waiting for the first exit; holds at all-ones.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == IDLE && wd_cnt_q != '1) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
    end
  end

  assign wd_fire = (state_q == IDLE) && (TIMEOUT_CYCLES != 32'd0) &&
                   (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      ack_sync_q <= '0;
      code_q     <= '0;
      pass_q     <= 1'b0;
      req_q      <= 1'b0;
      led_q      <= 1'b0;
      tmo_q      <= 1'b0;
      rpt_q      <= '0;
      blink_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= exit_valid_i;
      ack_sync_q <= {ack_sync_q[ACK_SYNC_STAGES-2:0], ps_ack_i};
      code_q     <= code_d;
      pass_q     <= pass_d;
      req_q      <= req_d;
      led_q      <= led_d;
      tmo_q      <= tmo_d;
      rpt_q      <= rpt_d;
      blink_q    <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pass_d  = pass_q;
    req_d   = req_q;
    led_d   = led_q;
    tmo_d   = tmo_q;
    rpt_d   = rpt_q;
    blink_d = blink_q;

    // Fail records blink from the capture edge onward.
    if (state_q != IDLE && !pass_q) begin
      blink_d = blink_q + 1'b1;
      if (blink_q == '1) led_d = ~led_q;
    end

    if (rise && state_q != IDLE && rpt_q != 8'hFF) begin
      rpt_d = rpt_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          code_d  = exit_value_i;
          pass_d  = (exit_value_i == 32'd0);
          req_d   = 1'b1;
          led_d   = 1'b1;
          blink_d = '0;
          state_d = REQ;
        end else if (wd_fire) begin
          code_d  = 32'hFFFF_FFFF;
          pass_d  = 1'b0;
          tmo_d   = 1'b1;
          req_d   = 1'b1;
          led_d   = 1'b1;
          blink_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACK_LOW;
        end
      end
      ACK_LOW: begin
        if (!ack_s) state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ps_req_o     = req_q;
  assign ps_code_o    = code_q;
  assign ps_pass_o    = pass_q;
  assign led_status_o = led_q;
  assign state_o      = state_q;
  assign repeat_cnt_o = rpt_q;
  assign timeout_o    = tmo_q;

endmodule
